conv_mac_array: RTL
===================

Name: conv_mac_array

Overview:
- Parametrised successor of the four-lane convolution data path. Computes one output_fm partial pixel per kernel window: LANES signed fixed-point in_fm×weight products per beat, a registered adder tree, and a window accumulator with explicit valid/last framing.
- Optionally adds the partial out_fm value read back, then rescales, saturates and emits a write-enable pulse.
- Sits between the in_fm/weight buffer readers and the out_fm buffer write port.

Parameters:
- DW, 16: signed width of each in_fm and weight element.
- LANES, 4: products per beat; power of two, at least 2.
- ACC_W, 48: accumulator width; wraps in two's complement.
- FRAC, 8: fractional bits in each operand; products carry 2*FRAC.
- OUT_W, 32: signed width of the partial-sum read data and the write data.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_last  in  1  last beat of the kernel window; ignored unless in_valid=1.
- in_fm_data  in  LANES*DW  lane i occupies [i*DW +: DW].
- weight  in  LANES*DW  same packing as in_fm_data.
- psum_en  in  1  add out_fm_rd_data to the result; sampled on the last beat.
- out_fm_rd_data  in  OUT_W  partial out_fm value; sampled on the last beat.
- out_fm_wr_ena  out  1  one-cycle pulse per completed window.
- out_fm_wr_data  out  OUT_W  result; valid only while out_fm_wr_ena=1.
- out_sat  out  1  saturation occurred in this result; qualified by out_fm_wr_ena.

Behaviour:
- Reset: all outputs 0; all pipeline valid/last/psum tags cleared; accumulator 0; first-beat flag set. Any window in flight is discarded and produces no pulse.
- Stage M (1 cycle): per-lane signed product, 2*DW bits, registered. The valid, last, psum_en and out_fm_rd_data tags are registered alongside.
- Stage T (log2(LANES) cycles): binary adder tree, one registered level per cycle. Operands are sign-extended to ACC_W. Tags travel with the data.
- Stage A (1 cycle), applied only when the tree-output valid=1:
  - if the first flag is set: acc <= sum;
  - otherwise: acc <= acc + sum.
  - The first flag takes the value of the tree-output last tag.
  - With tree-output valid=0, acc and the first flag hold.
- Stage O (1 cycle), triggered by a valid beat tagged last leaving stage A:
  - tot = acc + (psum_en ? sign_extend(out_fm_rd_data) << FRAC : 0), computed at ACC_W+1 bits;
  - r = tot >>> FRAC (arithmetic shift, rounding toward negative infinity);
  - if r is outside the signed OUT_W range: out_fm_wr_data = the clamped extreme and out_sat=1; otherwise out_fm_wr_data = r and out_sat=0.
  - Assert out_fm_wr_ena for exactly one cycle. On all other cycles out_fm_wr_ena=0 and out_sat=0; out_fm_wr_data holds its last value.
- Latency L = 3 + log2(LANES) (5 for the default). A last beat presented in cycle t produces out_fm_wr_ena in cycle t+L.
- Bubbles (in_valid=0) are allowed anywhere, inside or between windows.
- No backpressure: one beat is accepted per cycle.
- Back-to-back windows are allowed. A beat following a last beat starts a new window with no dead cycle, and consecutive windows give consecutive-cycle pulses.
- Single-beat window (first beat also last): acc = sum.
- in_last with in_valid=0 has no effect.
- Accumulator overflow wraps. Sizing ACC_W is the user's responsibility; only the output stage saturates.

Test Plan (defaults; 1.0 = 0x0100):
1. Single beat, all in_fm=0x0100, all weight=0x0200, in_last=1, psum_en=0 -> out_fm_wr_ena in cycle t+5 only; out_fm_wr_data=0x00000800; out_sat=0.
2. Three-beat window with the same operands, a 2-cycle bubble before the last beat, psum_en=1, out_fm_rd_data=0x00000100 -> exactly one pulse, 5 cycles after the last beat; data=0x00001900.
3. Back-to-back single-beat windows in consecutive cycles: weights 0x0200, then 0xFE00 -> pulses in consecutive cycles; data 0x00000800 then 0xFFFFF800.
4. Saturation:
   - in_fm=0x0100, weight=0x0100, psum_en=1, out_fm_rd_data=0x7FFFFFFF -> data 0x7FFFFFFF, out_sat=1.
   - Same window with weight=0xFF00 and out_fm_rd_data=0x80000000 -> data 0x80000000, out_sat=1.
5. Rounding: in_fm=0x0001, weight=0xFFFF in every lane, single beat -> tree sum -4, r=-1, data 0xFFFFFFFF, out_sat=0.
6. Reset mid-window: two non-last beats, rst high for 1 cycle, then a single last beat with test-1 operands -> no pulse for the flushed beats; a single pulse 5 cycles after the last beat with data 0x00000800.

Source files
------------

// File: rtl/conv_mac_array.sv
// conv_mac_array: LANES-wide signed MAC with a registered adder tree, window accumulator,
// optional partial-sum add, rescale and saturating output write.
module conv_mac_array #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int ACC_W = 48,
  parameter int FRAC  = 8,
  parameter int OUT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic [LANES*DW-1:0]   in_fm_data,
  input  logic [LANES*DW-1:0]   weight,
  input  logic                  psum_en,
  input  logic [OUT_W-1:0]      out_fm_rd_data,
  output logic                  out_fm_wr_ena,
  output logic [OUT_W-1:0]      out_fm_wr_data,
  output logic                  out_sat
);
  localparam int LG = $clog2(LANES);
  typedef struct packed {
    logic             v;
    logic             l;
    logic             p;
    logic [OUT_W-1:0] rd;
  } tag_t;
  logic signed [2*DW-1:0]  prod_d [LANES];
  logic signed [2*DW-1:0]  prod_q [LANES];
  logic signed [ACC_W-1:0] sum_d [LG][LANES];
  logic signed [ACC_W-1:0] sum_q [LG][LANES];
  tag_t                    tag_d [LG+1];
  tag_t                    tag_q [LG+1];
  tag_t                    tv;
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic                    first_d, first_q, fire_d, fire_q, ap_d, ap_q;
  logic [OUT_W-1:0]        ard_d, ard_q, wr_data_d, wr_data_q;
  logic                    wr_ena_d, wr_ena_q, sat_d, sat_q;
  logic signed [ACC_W:0]   tot, r;
  logic                    hi, lo;
  always_comb begin
    for (int i = 0; i < LANES; i++)
      prod_d[i] = (2*DW)'($signed(in_fm_data[i*DW +: DW])) * (2*DW)'($signed(weight[i*DW +: DW]));
    for (int k = 0; k < LG; k++)
      for (int j = 0; j < LANES; j++)
        sum_d[k][j] = '0;
    for (int j = 0; j < LANES/2; j++)
      sum_d[0][j] = ACC_W'(prod_q[2*j]) + ACC_W'(prod_q[2*j+1]);
    // level k only needs its first LANES>>(k+1) entries; the rest are don't-care
    for (int k = 1; k < LG; k++)
      for (int j = 0; j < LANES/2; j++)
        sum_d[k][j] = sum_q[k-1][2*j] + sum_q[k-1][2*j+1];
    tag_d[0] = {in_valid, in_valid & in_last, psum_en, out_fm_rd_data};
    for (int k = 0; k < LG; k++)
      tag_d[k+1] = tag_q[k];
    tv = tag_q[LG];
    acc_d = !tv.v ? acc_q : first_q ? sum_q[LG-1][0] : acc_q + sum_q[LG-1][0];
    first_d = tv.v ? tv.l : first_q;
    fire_d = tv.v & tv.l;
    ap_d = tv.p;
    ard_d = tv.rd;
    tot = {acc_q[ACC_W-1], acc_q} + (ap_q ? (ACC_W+1)'($signed(ard_q)) <<< FRAC : '0);
    r = tot >>> FRAC;
    hi = !r[ACC_W] && (|r[ACC_W-1:OUT_W-1]);
    lo = r[ACC_W] && !(&r[ACC_W-1:OUT_W-1]);
    wr_data_d = !fire_q ? wr_data_q : hi ? {1'b0, {(OUT_W-1){1'b1}}} : lo ? {1'b1, {(OUT_W-1){1'b0}}} : r[OUT_W-1:0];
    wr_ena_d = fire_q;
    sat_d = fire_q & (hi | lo);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q    <= '{default: '0};
      sum_q     <= '{default: '0};
      tag_q     <= '{default: '0};
      acc_q     <= '0;
      first_q   <= 1'b1;
      fire_q    <= 1'b0;
      ap_q      <= 1'b0;
      ard_q     <= '0;
      wr_data_q <= '0;
      wr_ena_q  <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      prod_q    <= prod_d;
      sum_q     <= sum_d;
      tag_q     <= tag_d;
      acc_q     <= acc_d;
      first_q   <= first_d;
      fire_q    <= fire_d;
      ap_q      <= ap_d;
      ard_q     <= ard_d;
      wr_data_q <= wr_data_d;
      wr_ena_q  <= wr_ena_d;
      sat_q     <= sat_d;
    end
  end
  assign out_fm_wr_ena  = wr_ena_q;
  assign out_fm_wr_data = wr_data_q;
  assign out_sat        = sat_q;
endmodule
